char_fetch_sched: RTL and testbench
===================================

CHAR_FETCH_SCHED -- requirements
Module: char_fetch_sched

Interface
REQ-001 Parameter X0, default 288, is the left pixel column of the 4-character text window.
REQ-002 Parameter Y0, default 232, is the top pixel row of the text window.
REQ-003 Parameter VBLANK_Y, default 480, is the first pixely value treated as vertical blanking.
REQ-004 clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the clock rising edge.
REQ-006 pixelx  input  10  current horizontal pixel coordinate.
REQ-007 pixely  input  10  current vertical pixel coordinate.
REQ-008 video_on  input  1  high while pixelx/pixely lie in the visible area.
REQ-009 Dir0, Dir1, Dir2, Dir3  input  7 each  new character codes offered for slots 0..3 (slot 0 leftmost).
REQ-010 upd_req  input  1  request to load Dir0..Dir3; held high until upd_ack is seen.
REQ-011 upd_ack  output  1  one-cycle pulse; Dir0..Dir3 captured on this cycle.
REQ-012 rom_addr  output  11  character ROM address = {code[6:0], row[3:0]}.
REQ-013 bit_col  output  3  column within the 8-pixel glyph row (0 = leftmost).
REQ-014 slot  output  2  index of the character slot being fetched.
REQ-015 pix_en  output  1  high when rom_addr/bit_col/slot are valid for the current pixel.

Function
REQ-016 The window SHALL be 4 cells of 8x16 pixels: X0 <= pixelx < X0+32 and Y0 <= pixely < Y0+16, qualified by video_on.
REQ-017 The block SHALL hold four 7-bit shadow code registers; display SHALL use only the shadow codes, never Dir0..Dir3 directly.
REQ-018 Pipeline stage 1 SHALL register in_win, slot = (pixelx-X0)[4:3], col = (pixelx-X0)[2:0], and row = (pixely-Y0)[3:0]; subtraction SHALL be 10-bit, with only the low bits used when in_win is true.
REQ-019 Stage 2 SHALL register rom_addr = {shadow[slot], row}, bit_col = col, slot, and pix_en = in_win; total latency from pixel coordinates to outputs SHALL be exactly 2 cycles.
REQ-020 When stage-1 in_win is 0, stage 2 SHALL drive pix_en=0, rom_addr=0, bit_col=0, slot=0.
REQ-021 The update FSM SHALL have the states IDLE, WAIT_VB, LATCH and HOLD.
REQ-022 IDLE -> WAIT_VB when upd_req=1; otherwise the FSM stays in IDLE.
REQ-023 WAIT_VB -> LATCH when upd_req=1 and pixely >= VBLANK_Y; WAIT_VB -> IDLE when upd_req=0 (request withdrawn, no capture); otherwise the FSM stays in WAIT_VB.
REQ-024 In LATCH, for exactly one cycle, upd_ack SHALL be 1 and shadow[i] SHALL take Dir_i on that clock edge; the FSM then goes to HOLD.
REQ-025 HOLD -> IDLE when upd_req=0; while upd_req stays high the FSM SHALL stay in HOLD and SHALL NOT issue a second ack.
REQ-026 upd_ack SHALL be 0 in every state other than LATCH.
REQ-027 Shadow codes SHALL change only in LATCH; a request made mid-frame SHALL be deferred until blanking, so a frame never shows mixed old and new codes.
REQ-028 If upd_req is high and pixely >= VBLANK_Y on the same edge that IDLE is left, the FSM SHALL still pass through WAIT_VB, giving a minimum request-to-ack delay of 2 cycles.
REQ-029 pixelx/pixely wrap-around (e.g. 799->0) SHALL need no special handling; window decode is purely combinational on the current coordinates.

Reset
REQ-030 While reset=0 at a clock edge: FSM SHALL go to IDLE; upd_ack, pix_en, rom_addr, bit_col and slot SHALL be 0; pipeline valid bits SHALL be cleared; all shadow codes SHALL be 7'h20.
REQ-031 Reset during WAIT_VB, LATCH or HOLD SHALL abort the handshake with no capture in that cycle; after release, a still-high upd_req SHALL start a new handshake from IDLE.

Verification
REQ-032 Reset release; pixelx=X0+9, pixely=Y0+3, video_on=1 -> two cycles later pix_en=1, slot=1, bit_col=1, rom_addr={7'h20,4'h3}.
REQ-033 Pixel at pixelx=X0+32 or pixely=Y0+16, or with video_on=0 inside the window -> pix_en=0, rom_addr=0 two cycles later.
REQ-034 upd_req=1 with Dir0..3=7'h31,7'h32,7'h33,7'h34 at pixely=100 -> no upd_ack until pixely reaches 480; then one upd_ack pulse; next frame slot 3 fetches rom_addr={7'h34,row}.
REQ-035 upd_req held high for 10 cycles after upd_ack -> exactly one ack; FSM returns to IDLE on the cycle after upd_req falls.
REQ-036 upd_req dropped while in WAIT_VB -> no ack and shadow codes unchanged; reset=0 asserted in HOLD -> shadow codes = 7'h20 and upd_ack=0.

Source files
------------

// File: rtl/char_fetch_sched.sv
// char_fetch_sched: 4-cell text window fetch pipeline with
// blanking-synchronised shadow code update handshake.
module char_fetch_sched #(
   parameter int X0       = 288,
   parameter int Y0       = 232,
   parameter int VBLANK_Y = 480
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [9:0]  pixelx,
   input  logic [9:0]  pixely,
   input  logic        video_on,
   input  logic [6:0]  Dir0,
   input  logic [6:0]  Dir1,
   input  logic [6:0]  Dir2,
   input  logic [6:0]  Dir3,
   input  logic        upd_req,
   output logic        upd_ack,
   output logic [10:0] rom_addr,
   output logic [2:0]  bit_col,
   output logic [1:0]  slot,
   output logic        pix_en
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_VB,
      LATCH,
      HOLD
   } state_t;

   localparam logic [10:0] XLO = 11'(X0);
   localparam logic [10:0] XHI = 11'(X0 + 32);
   localparam logic [10:0] YLO = 11'(Y0);
   localparam logic [10:0] YHI = 11'(Y0 + 16);
   localparam logic [10:0] VBL = 11'(VBLANK_Y);
   localparam logic [4:0]  XOFF = 5'(X0);
   localparam logic [3:0]  YOFF = 4'(Y0);

   state_t      state_q;
   logic        upd_ack_q;
   logic [6:0]  shadow_q [4];

   logic        win_d;
   logic [4:0]  dx_d;
   logic [3:0]  dy_d;
   logic        vblank_d;

   logic        win_q;
   logic [1:0]  slot1_q;
   logic [2:0]  col1_q;
   logic [3:0]  row1_q;

   logic [10:0] rom_addr_q;
   logic [2:0]  bit_col_q;
   logic [1:0]  slot_q;
   logic        pix_en_q;

   // Window decode on the live coordinates; the low bits of the
   // 10-bit offset equal the difference of the low bits alone.
   always_comb begin
      win_d = video_on
            && ({1'b0, pixelx} >= XLO) && ({1'b0, pixelx} < XHI)
            && ({1'b0, pixely} >= YLO) && ({1'b0, pixely} < YHI);
      dx_d = pixelx[4:0] - XOFF;
      dy_d = pixely[3:0] - YOFF;
      vblank_d = ({1'b0, pixely} >= VBL);
   end

   // Stage 1: register window hit and cell coordinates.
   always_ff @(posedge clock) begin
      if (!reset) begin
         win_q   <= 1'b0;
         slot1_q <= 2'd0;
         col1_q  <= 3'd0;
         row1_q  <= 4'd0;
      end else begin
         win_q   <= win_d;
         slot1_q <= dx_d[4:3];
         col1_q  <= dx_d[2:0];
         row1_q  <= dy_d;
      end
   end

   // Stage 2: look up the shadow code and form the ROM address.
   always_ff @(posedge clock) begin
      if (!reset || !win_q) begin
         rom_addr_q <= 11'd0;
         bit_col_q  <= 3'd0;
         slot_q     <= 2'd0;
         pix_en_q   <= 1'b0;
      end else begin
         rom_addr_q <= {shadow_q[slot1_q], row1_q};
         bit_col_q  <= col1_q;
         slot_q     <= slot1_q;
         pix_en_q   <= 1'b1;
      end
   end

   // Update FSM: defer capture of new codes to vertical blanking.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         upd_ack_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            shadow_q[i] <= 7'h20;
         end
      end else begin
         upd_ack_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (upd_req) state_q <= WAIT_VB;
            end
            WAIT_VB: begin
               if (!upd_req) begin
                  state_q <= IDLE;
               end else if (vblank_d) begin
                  state_q   <= LATCH;
                  upd_ack_q <= 1'b1;
               end
            end
            LATCH: begin
               shadow_q[0] <= Dir0;
               shadow_q[1] <= Dir1;
               shadow_q[2] <= Dir2;
               shadow_q[3] <= Dir3;
               state_q     <= HOLD;
            end
            HOLD: begin
               if (!upd_req) state_q <= IDLE;
            end
         endcase
      end
   end

   assign upd_ack  = upd_ack_q;
   assign rom_addr = rom_addr_q;
   assign bit_col  = bit_col_q;
   assign slot     = slot_q;
   assign pix_en   = pix_en_q;

endmodule

// File: tb/tb_char_fetch_sched.sv
// tb_char_fetch_sched: scoreboard bench for the text window
// fetch pipeline and the shadow code update handshake.
module tb_char_fetch_sched;

   localparam int X0 = 288;
   localparam int Y0 = 232;
   localparam int VB = 480;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  pixelx = '0;
   logic [9:0]  pixely = '0;
   logic        video_on = 1'b0;
   logic [6:0]  Dir0 = '0;
   logic [6:0]  Dir1 = '0;
   logic [6:0]  Dir2 = '0;
   logic [6:0]  Dir3 = '0;
   logic        upd_req = 1'b0;
   logic        upd_ack;
   logic [10:0] rom_addr;
   logic [2:0]  bit_col;
   logic [1:0]  slot;
   logic        pix_en;

   char_fetch_sched #(.X0(X0), .Y0(Y0), .VBLANK_Y(VB)) dut (
      .clock   (clock),
      .reset   (reset),
      .pixelx  (pixelx),
      .pixely  (pixely),
      .video_on(video_on),
      .Dir0    (Dir0),
      .Dir1    (Dir1),
      .Dir2    (Dir2),
      .Dir3    (Dir3),
      .upd_req (upd_req),
      .upd_ack (upd_ack),
      .rom_addr(rom_addr),
      .bit_col (bit_col),
      .slot    (slot),
      .pix_en  (pix_en)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit         win;
      bit         z;
      logic [1:0] sl;
      logic [2:0] col;
      logic [3:0] row;
   } ent_t;

   typedef enum int {M_IDLE, M_WAIT, M_LATCH, M_HOLD} mst_t;

   ent_t       q[$];
   mst_t       m_st = M_IDLE;
   logic [6:0] m_sh [4] = '{7'h20, 7'h20, 7'h20, 7'h20};
   logic       m_ack = 1'b0;
   int         checks = 0;
   int         fails = 0;
   int         acks = 0;

   task automatic cyc();
      ent_t        e;
      logic [16:0] exp_v;
      logic [16:0] obs_v;
      @(posedge clock);
      #1;
      if (!reset) begin
         foreach (q[i]) q[i].z = 1'b1;
      end
      if (q.size() == 2) begin
         e = q.pop_front();
         if (e.z || !e.win) exp_v = '0;
         else exp_v = {1'b1, e.sl, e.col, m_sh[e.sl], e.row};
         obs_v = {pix_en, slot, bit_col, rom_addr};
         checks++;
         assert (obs_v === exp_v) else begin
            fails++;
            $error("FAIL pix obs=%h exp=%h", obs_v, exp_v);
         end
      end
      if (!reset) begin
         m_st = M_IDLE;
         for (int i = 0; i < 4; i++) m_sh[i] = 7'h20;
      end else begin
         case (m_st)
            M_IDLE:  if (upd_req) m_st = M_WAIT;
            M_WAIT: begin
               if (!upd_req) m_st = M_IDLE;
               else if (int'(pixely) >= VB) m_st = M_LATCH;
            end
            M_LATCH: begin
               m_sh[0] = Dir0;
               m_sh[1] = Dir1;
               m_sh[2] = Dir2;
               m_sh[3] = Dir3;
               m_st = M_HOLD;
            end
            default: if (!upd_req) m_st = M_IDLE;
         endcase
      end
      m_ack = (m_st == M_LATCH);
      if (upd_ack === 1'b1) acks++;
      checks++;
      assert (upd_ack === m_ack) else begin
         fails++;
         $error("FAIL ack obs=%b exp=%b", upd_ack, m_ack);
      end
   endtask

   task automatic step(input int px, input int py, input logic vo);
      ent_t e;
      pixelx = 10'(px);
      pixely = 10'(py);
      video_on = vo;
      e.z   = 1'b0;
      e.win = vo && px >= X0 && px < X0 + 32
              && py >= Y0 && py < Y0 + 16;
      e.sl  = 2'((px - X0) >> 3);
      e.col = 3'(px - X0);
      e.row = 4'(py - Y0);
      q.push_back(e);
      cyc();
   endtask

   task automatic hold(input int n, input int py);
      for (int i = 0; i < n; i++) step(0, py, 1'b0);
   endtask

   task automatic scan(input int py);
      for (int i = 0; i < 36; i++) step(X0 - 2 + i, py, 1'b1);
   endtask

   task automatic chk_acks(input string tag, input int want);
      checks++;
      assert (acks == want) else begin
         fails++;
         $error("FAIL %s acks=%0d exp=%0d", tag, acks, want);
      end
      acks = 0;
   endtask

   initial begin
      reset = 1'b0;
      hold(3, 0);
      reset = 1'b1;
      step(X0 + 9, Y0 + 3, 1'b1);
      step(X0 + 9, Y0 + 3, 1'b1);
      scan(Y0 + 3);
      step(X0 + 32, Y0 + 5, 1'b1);
      step(X0 + 31, Y0 + 16, 1'b1);
      step(X0 + 5, Y0 + 5, 1'b0);
      step(X0 + 5, Y0 - 1, 1'b1);
      step(X0, Y0, 1'b1);
      step(X0 + 31, Y0 + 15, 1'b1);
      step(X0 - 1, Y0 + 15, 1'b1);
      // deferred update: request mid-frame, ack only in blanking
      Dir0 = 7'h31; Dir1 = 7'h32; Dir2 = 7'h33; Dir3 = 7'h34;
      upd_req = 1'b1;
      hold(5, 100);
      scan(Y0 + 7);
      hold(2, VB - 1);
      hold(3, VB);
      chk_acks("first_ack", 1);
      hold(10, VB + 2);
      chk_acks("held_req", 0);
      upd_req = 1'b0;
      hold(2, VB + 3);
      scan(Y0 + 5);
      // withdrawn request: no capture
      Dir0 = 7'h41; Dir1 = 7'h42; Dir2 = 7'h43; Dir3 = 7'h44;
      upd_req = 1'b1;
      hold(3, 100);
      upd_req = 1'b0;
      hold(2, 100);
      hold(3, VB);
      chk_acks("withdrawn", 0);
      scan(Y0 + 9);
      // reset while in HOLD
      Dir0 = 7'h51; Dir1 = 7'h52; Dir2 = 7'h53; Dir3 = 7'h54;
      upd_req = 1'b1;
      hold(5, VB);
      chk_acks("pre_reset", 1);
      reset = 1'b0;
      hold(2, VB);
      upd_req = 1'b0;
      reset = 1'b1;
      hold(1, VB);
      scan(Y0 + 2);
      // reset in WAIT_VB, request kept high across release
      upd_req = 1'b1;
      hold(1, 100);
      hold(1, 100);
      reset = 1'b0;
      hold(2, VB);
      chk_acks("reset_wait", 0);
      reset = 1'b1;
      hold(4, VB);
      chk_acks("restart", 1);
      upd_req = 1'b0;
      hold(2, 0);
      scan(Y0 + 15);
      hold(3, 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
